// File: rtl/pulse_scheduler_if.sv
// Request/status bundle between a requester and the pulse scheduler.
interface pulse_scheduler_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic [WIDTH-1:0] count;
  logic             signal;
  logic             busy;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] pulses;

  modport master (
    output start, stop, period, high_time, count,
    input  signal, busy, done, err, pulses
  );

  modport slave (
    input  start, stop, period, high_time, count,
    output signal, busy, done, err, pulses
  );
endinterface

// File: rtl/pulse_scheduler.sv
// Programmable pulse-train controller: emits bursts (or a continuous train)
// of pulses with latched period/high time, reports progress and completion.
module pulse_scheduler #(
  parameter int unsigned WIDTH = 8
) (
  input logic              clock,
  input logic              reset,
  pulse_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW, DONE} state_t;

  state_t           state_q, state_d;
  logic             signal_q, signal_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] pulses_q, pulses_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             cfg_ok;

  assign cfg_ok = (bus.period >= WIDTH'(2)) && (bus.high_time != '0) &&
                  (bus.high_time < bus.period);

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      pulses_q <= '0;
      phase_q  <= '0;
      per_q    <= '0;
      hi_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      pulses_q <= pulses_d;
      phase_q  <= phase_d;
      per_q    <= per_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state and next-output logic; phase counts 1..period within a period
  always_comb begin
    state_d  = state_q;
    signal_d = signal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    pulses_d = pulses_q;
    phase_d  = phase_q;
    per_d    = per_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          if (cfg_ok) begin
            per_d    = bus.period;
            hi_d     = bus.high_time;
            cnt_d    = bus.count;
            state_d  = HIGH;
            signal_d = 1'b1;
            busy_d   = 1'b1;
            pulses_d = WIDTH'(1);
            phase_d  = WIDTH'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      HIGH: begin
        if (bus.stop) begin
          state_d  = DONE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          phase_d = phase_q + 1'b1;
          if (phase_q == hi_q) begin
            state_d  = LOW;
            signal_d = 1'b0;
          end
        end
      end
      LOW: begin
        if (bus.stop) begin
          state_d  = DONE;
          signal_d = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else if (phase_q == per_q) begin
          if ((cnt_q != '0) && (pulses_q == cnt_q)) begin
            state_d  = DONE;
            signal_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            state_d  = HIGH;
            signal_d = 1'b1;
            phase_d  = WIDTH'(1);
            pulses_d = (pulses_q == '1) ? pulses_q : pulses_q + 1'b1;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        signal_d = 1'b0;
        busy_d   = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        signal_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  assign bus.signal = signal_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.pulses = pulses_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed bench for pulse_scheduler: outputs are checked 1 time unit after
// each rising edge as the vector {signal, busy, done, err, pulses}.
module tb_pulse_scheduler;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pulse_scheduler_if #(.WIDTH(8)) bus ();

  pulse_scheduler #(.WIDTH(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] ev(bit s, bit b, bit d, bit e, logic [7:0] p);
    return {s, b, d, e, p};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(string tag, logic [11:0] exp);
    logic [11:0] obs;
    obs = {bus.signal, bus.busy, bus.done, bus.err, bus.pulses};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed sig/busy/done/err/pulses=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
             tag, obs[11], obs[10], obs[9], obs[8], obs[7:0],
             exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic cfg(logic [7:0] p, logic [7:0] h, logic [7:0] c);
    bus.period    = p;
    bus.high_time = h;
    bus.count     = c;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    cfg(8'd0, 8'd0, 8'd0);

    // Reset state
    repeat (2) step();
    chk("reset_held", ev(0, 0, 0, 0, 8'd0));
    reset = 1'b0;
    step();
    chk("reset_released", ev(0, 0, 0, 0, 8'd0));

    // Basic burst: period 4, high 1, count 3
    cfg(8'd4, 8'd1, 8'd3);
    bus.start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      bus.start = 1'b0;
      chk($sformatf("burst_k%0d", k), ev(k % 4 == 0, 1, 0, 0, 8'(k / 4 + 1)));
    end
    step();
    chk("burst_done", ev(0, 0, 1, 0, 8'd3));
    step();
    chk("burst_idle", ev(0, 0, 0, 0, 8'd3));

    // Continuous square wave, stopped after 15 clocks
    cfg(8'd2, 8'd1, 8'd0);
    bus.start = 1'b1;
    for (int k = 0; k < 15; k++) begin
      step();
      bus.start = 1'b0;
      chk($sformatf("square_k%0d", k), ev(k % 2 == 0, 1, 0, 0, 8'(k / 2 + 1)));
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("square_stop", ev(0, 0, 1, 0, 8'd8));
    step();
    chk("square_idle", ev(0, 0, 0, 0, 8'd8));

    // Invalid configs: high_time == period, period < 2, high_time == 0
    cfg(8'd3, 8'd3, 8'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("inv_hi_eq_per", ev(0, 0, 0, 1, 8'd8));
    step();
    chk("inv_hi_eq_per_clr", ev(0, 0, 0, 0, 8'd8));
    cfg(8'd1, 8'd1, 8'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("inv_per1", ev(0, 0, 0, 1, 8'd8));
    step();
    chk("inv_per1_clr", ev(0, 0, 0, 0, 8'd8));
    cfg(8'd5, 8'd0, 8'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("inv_hi0", ev(0, 0, 0, 1, 8'd8));
    step();
    chk("inv_hi0_clr", ev(0, 0, 0, 0, 8'd8));

    // Start while busy with a different config: ignored, config not resampled
    cfg(8'd6, 8'd2, 8'd2);
    bus.start = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      bus.start = (k == 2 || k == 6);
      if (k == 2) cfg(8'd3, 8'd1, 8'd5);
      chk($sformatf("busy_k%0d", k), ev(k % 6 < 2, 1, 0, 0, 8'(k / 6 + 1)));
    end
    bus.start = 1'b0;
    step();
    chk("busy_done", ev(0, 0, 1, 0, 8'd2));
    step();
    chk("busy_idle", ev(0, 0, 0, 0, 8'd2));

    // Reset between edges while in HIGH clears outputs without a clock
    cfg(8'd4, 8'd3, 8'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("rst_pre_high", ev(1, 1, 0, 0, 8'd1));
    #2 reset = 1'b1;
    #1;
    chk("rst_async", ev(0, 0, 0, 0, 8'd0));
    #2 reset = 1'b0;
    step();
    chk("rst_after", ev(0, 0, 0, 0, 8'd0));
    cfg(8'd3, 8'd1, 8'd1);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("rst_restart_k0", ev(1, 1, 0, 0, 8'd1));
    step();
    chk("rst_restart_k1", ev(0, 1, 0, 0, 8'd1));
    step();
    chk("rst_restart_k2", ev(0, 1, 0, 0, 8'd1));
    step();
    chk("rst_restart_done", ev(0, 0, 1, 0, 8'd1));
    step();
    chk("rst_restart_idle", ev(0, 0, 0, 0, 8'd1));

    // Start and stop together in IDLE: nothing happens
    cfg(8'd4, 8'd2, 8'd1);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    chk("startstop", ev(0, 0, 0, 0, 8'd1));
    step();
    chk("startstop_after", ev(0, 0, 0, 0, 8'd1));

    // Continuous pulse counter saturates at 255 while the wave continues
    cfg(8'd2, 8'd1, 8'd0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (599) step();
    chk("sat_k599", ev(0, 1, 0, 0, 8'd255));
    step();
    chk("sat_k600", ev(1, 1, 0, 0, 8'd255));
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk("sat_stop", ev(0, 0, 1, 0, 8'd255));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_scheduler.md
# pulse_scheduler

Programmable pulse-train controller that sequences the lab's pulse generator from a single system clock. It replaces free-running `#delay` pulse sources with a synthesizable FSM. A requester loads period, high time and burst length and strobes `start`. The block emits the pulse train on `signal`, reports progress, and signals completion or abort.

## Interface
- `WIDTH`, 8: width of the period, high-time, count and pulse-counter fields.

- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a burst; sampled only in IDLE.
- `stop`  in  1  abort a running burst.
- `period`  in  WIDTH  clocks per pulse period; valid range 2..2^WIDTH-1.
- `high_time`  in  WIDTH  clocks `signal` is high per period; valid range 1..period-1.
- `count`  in  WIDTH  pulses per burst; 0 = continuous until `stop`.
- `signal`  out  1  pulse output (registered).
- `busy`  out  1  high while in HIGH or LOW.
- `done`  out  1  one-cycle strobe when a burst ends (normal or aborted).
- `err`  out  1  one-cycle strobe when `start` carries an invalid config.
- `pulses`  out  WIDTH  rising edges emitted since the last accepted start.

## Operation
- States: IDLE, HIGH, LOW, DONE.
- Reset (async, any state): state=IDLE; `signal`=0, `busy`=0, `done`=0, `err`=0, `pulses`=0; latched config and phase counter cleared.
- IDLE, `start`=1, `stop`=0, config valid:
  - latch `period`, `high_time`, `count`;
  - go to HIGH; `signal`=1; `pulses`=1; phase=1.
- IDLE, `start`=1, config invalid (period<2, high_time=0 or high_time>=period):
  - stay IDLE; `err`=1 for one cycle; `pulses` unchanged.
- IDLE, `start`=1 and `stop`=1 in the same cycle: `stop` wins; the start is ignored and neither `err` nor `done` fires.
- HIGH:
  - the phase counter increments each clock;
  - when phase=high_time, go to LOW with `signal`=0.
- LOW:
  - continues until phase=period;
  - at phase=period, if count≠0 and pulses=count, go to DONE;
  - otherwise go to HIGH, set `signal`=1, increment `pulses` and reset phase to 1.
- `pulses` saturates at 2^WIDTH-1 in continuous mode; the wave itself continues.
- `stop`=1 in HIGH or LOW: go to DONE on the next edge, with `signal`=0 from that edge. A partial pulse is truncated and not retracted from `pulses`.
- DONE: lasts exactly one cycle with `done`=1, `busy`=0, `signal`=0, then returns to IDLE.
- `start` in HIGH, LOW or DONE is ignored; it is not queued.
- Config inputs are sampled only at an accepted start; changes mid-burst have no effect.
- `pulses` holds its final value in IDLE until the next accepted start.

## Timing
- All outputs are registered. Latency from `start` sampled at edge n to `signal`=1, `busy`=1, `pulses`=1 is visible after edge n.
- Each period is exactly `period` clocks: `high_time` clocks high, then `period-high_time` clocks low.
- For a burst started at edge n, `done`=1 after edge n+count·period, and the block is back in IDLE after edge n+count·period+1. A new `start` is accepted at that edge or later.
- `stop` sampled at edge m: `signal`=0, `busy`=0, `done`=1 after edge m.
- `err` asserts after the sampling edge and lasts one cycle.
- Reset is asynchronous: outputs clear immediately on `reset` rising, without waiting for a clock edge. Release is synchronous in effect: the first state change happens on the first edge with `reset`=0.

## Test plan
- Basic burst: period=4, high_time=1, count=3, `start` at edge 5.
  - `signal` high after edges 5, 9 and 13, each time for 1 clock;
  - `pulses` reads 1, 2, 3;
  - `done` after edge 17; `busy` low from edge 17.
- Square wave, continuous: period=2, high_time=1, count=0.
  - `signal` toggles every clock;
  - `stop` at edge 20 gives `signal`=0 and `done`=1 after edge 20, then IDLE.
- Invalid config: period=3, high_time=3, `start`.
  - `err`=1 for one cycle; `busy` stays 0 and `pulses` is unchanged.
  - Repeat with period=1 and with high_time=0: same response.
- Start while busy: a second `start` with different config during a period=6, count=2 burst.
  - Burst timing is unchanged (12 busy clocks); no restart and no `err`.
- Reset mid-operation: assert `reset` between edges while in HIGH.
  - `signal`, `busy` and `pulses` go to 0 immediately, before the next clock.
  - After release, a new `start` runs normally from `pulses`=1.
- Start and stop together in IDLE: the start is ignored; `busy`, `done` and `err` all stay 0.
